// File: rtl/spi_register_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : spi_register_slave                                         |
// | Purpose : SPI frame receiver issuing register write/read strobes.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module spi_register_slave #(
  parameter int          ADDR_W = 8,
  parameter int          DATA_W = 16,
  parameter logic [7:0]  CMD_WR = 8'h02,
  parameter logic [7:0]  CMD_RD = 8'h01
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              enable_n,
  input  logic              latch_data_n,
  input  logic              ss_n,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err
);

  localparam int c_FRAME_W = 8 + ADDR_W + DATA_W;
  localparam int c_CNT_W   = $clog2(c_FRAME_W + 2);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_FRAME_W);
  localparam int c_EN   = 4;
  localparam int c_LAT  = 3;
  localparam int c_SS   = 2;
  localparam int c_SCK  = 1;
  localparam int c_MOSI = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_HOLD  = 3'd2,
    S_EXEC  = 3'd3,
    S_RDCAP = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [4:0]            w_pins;
  logic [4:0]            r_meta;
  logic [4:0]            r_sync;
  logic                  r_ss_prev;
  logic                  r_sck_prev;
  logic                  r_lat_prev;
  logic                  r_latch_fall;
  logic [c_FRAME_W-1:0]  r_rx;
  logic [c_CNT_W-1:0]    r_bit_cnt;
  logic [c_FRAME_W-1:0]  r_cmd_buf;
  logic [c_FRAME_W-1:0]  r_tx_buf;
  logic [c_FRAME_W-1:0]  r_tx_sr;
  logic [ADDR_W-1:0]     r_reg_addr;
  logic [DATA_W-1:0]     r_reg_wdata;
  logic                  r_frame_err;
  logic                  w_en;
  logic                  w_ss_fall;
  logic                  w_ss_rise;
  logic                  w_sck_rise;
  logic                  w_sck_fall;
  logic                  w_frame_err;
  logic                  w_load_cmd;
  logic                  w_clr_rx;
  logic [7:0]            w_buf_cmd;
  logic [ADDR_W-1:0]     w_buf_addr;
  logic [DATA_W-1:0]     w_buf_data;

  assign w_pins = {enable_n, latch_data_n, ss_n, sclk, mosi};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_meta       <= '0;
      r_sync       <= '0;
      r_ss_prev    <= 1'b0;
      r_sck_prev   <= 1'b0;
      r_lat_prev   <= 1'b0;
      r_latch_fall <= 1'b0;
    end else begin
      r_meta       <= w_pins;
      r_sync       <= r_meta;
      r_ss_prev    <= r_sync[c_SS];
      r_sck_prev   <= r_sync[c_SCK];
      r_lat_prev   <= r_sync[c_LAT];
      r_latch_fall <= r_lat_prev & ~r_sync[c_LAT];
    end
  end

  assign w_en       = ~r_sync[c_EN];
  assign w_ss_fall  = r_ss_prev & ~r_sync[c_SS];
  assign w_ss_rise  = ~r_ss_prev & r_sync[c_SS];
  assign w_sck_rise = ~r_sck_prev & r_sync[c_SCK];
  assign w_sck_fall = r_sck_prev & ~r_sync[c_SCK];

  assign w_buf_cmd  = r_cmd_buf[c_FRAME_W-1 -: 8];
  assign w_buf_addr = r_cmd_buf[DATA_W +: ADDR_W];
  assign w_buf_data = r_cmd_buf[DATA_W-1:0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_frame_err = 1'b0;
    w_load_cmd  = 1'b0;
    w_clr_rx    = 1'b0;
    if (!w_en) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ss_fall) begin
            w_next   = S_SHIFT;
            w_clr_rx = 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_ss_rise) begin
            if (r_bit_cnt == c_CNT_FULL) begin
              w_next     = S_HOLD;
              w_load_cmd = 1'b1;
            end else begin
              w_next      = S_IDLE;
              w_frame_err = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_ss_fall) begin
            w_next   = S_SHIFT;
            w_clr_rx = 1'b1;
          end else if (r_latch_fall && r_sync[c_SS]) begin
            w_next = S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_buf_cmd == CMD_RD) begin
            w_next = S_RDCAP;
          end else begin
            w_next      = S_IDLE;
            w_frame_err = (w_buf_cmd != CMD_WR);
          end
        end
        S_RDCAP: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Receive path: one bit per synchronized sclk rise, counter parks at FULL+1.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_rx      <= '0;
      r_bit_cnt <= '0;
      r_cmd_buf <= '0;
    end else begin
      if (w_clr_rx) begin
        r_rx      <= '0;
        r_bit_cnt <= '0;
      end else if (r_state == S_SHIFT && w_en && w_sck_rise) begin
        if (r_bit_cnt < c_CNT_FULL) begin
          r_rx      <= {r_rx[c_FRAME_W-2:0], r_sync[c_MOSI]};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end else if (r_bit_cnt == c_CNT_FULL) begin
          r_bit_cnt <= c_CNT_FULL + 1'b1;
        end
      end
      if (w_load_cmd) begin
        r_cmd_buf <= r_rx;
      end
    end
  end

  // Address/data are loaded as EXEC is entered so they line up with the strobe.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      if (r_state == S_HOLD && w_next == S_EXEC) begin
        if (w_buf_cmd == CMD_WR) begin
          r_reg_addr  <= w_buf_addr;
          r_reg_wdata <= w_buf_data;
        end else if (w_buf_cmd == CMD_RD) begin
          r_reg_addr  <= w_buf_addr;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_tx_buf <= '0;
      r_tx_sr  <= '0;
    end else begin
      if (r_state == S_RDCAP && w_en) begin
        r_tx_buf <= {CMD_RD, w_buf_addr, reg_rdata};
      end
      if (w_en && w_ss_fall) begin
        r_tx_sr <= r_tx_buf;
      end else if (w_en && !r_sync[c_SS] && w_sck_fall) begin
        r_tx_sr <= {r_tx_sr[c_FRAME_W-2:0], 1'b0};
      end
    end
  end

  assign reg_wr_en = (r_state == S_EXEC) && w_en && (w_buf_cmd == CMD_WR);
  assign reg_rd_en = (r_state == S_EXEC) && w_en && (w_buf_cmd == CMD_RD);
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;
  assign frame_err = r_frame_err;
  assign miso      = r_tx_sr[c_FRAME_W-1] & ~r_sync[c_SS] & w_en;

endmodule
`default_nettype wire

// File: tb/tb_spi_register_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_spi_register_slave                                      |
// | Purpose : Directed self-checking bench for spi_register_slave.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_spi_register_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_n = 1'b0;
  logic        latch_data_n = 1'b1;
  logic        ss_n = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic [15:0] reg_rdata = 16'h0000;
  logic        miso;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        frame_err;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int ferr_cnt = 0;
  int ss_hi    = 0;
  int en_off   = 0;
  logic rst_q  = 1'b1;

  // Model state
  int          exp_wr_cyc = -1;
  int          exp_rd_cyc = -1;
  logic [7:0]  exp_saddr  = 8'h00;
  logic [15:0] exp_sdata  = 16'h0000;
  logic [7:0]  m_addr     = 8'h00;
  logic [15:0] m_wdata    = 16'h0000;
  logic [31:0] m_tx       = 32'h0;
  logic        pend_v     = 1'b0;
  logic [31:0] pend_w     = 32'h0;

  spi_register_slave dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .enable_n     (enable_n),
    .latch_data_n (latch_data_n),
    .ss_n         (ss_n),
    .sclk         (sclk),
    .mosi         (mosi),
    .miso         (miso),
    .reg_wr_en    (reg_wr_en),
    .reg_rd_en    (reg_rd_en),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %0s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst_q) begin
        m_addr  = 8'h00;
        m_wdata = 16'h0000;
        check("rst_frame_err", {31'b0, frame_err}, 32'h0);
        check("rst_miso", {31'b0, miso}, 32'h0);
      end
      if (cyc == exp_wr_cyc) begin
        m_addr  = exp_saddr;
        m_wdata = exp_sdata;
      end
      if (cyc == exp_rd_cyc) m_addr = exp_saddr;
      check("reg_wr_en", {31'b0, reg_wr_en}, {31'b0, (cyc == exp_wr_cyc)});
      check("reg_rd_en", {31'b0, reg_rd_en}, {31'b0, (cyc == exp_rd_cyc)});
      check("reg_addr", {24'b0, reg_addr}, {24'b0, m_addr});
      check("reg_wdata", {16'b0, reg_wdata}, {16'b0, m_wdata});
      ss_hi  = ss_n ? ss_hi + 1 : 0;
      en_off = enable_n ? en_off + 1 : 0;
      if (ss_hi >= 3 || en_off >= 3) check("miso_idle", {31'b0, miso}, 32'h0);
      if (reg_wr_en) wr_cnt++;
      if (reg_rd_en) rd_cnt++;
      if (frame_err) ferr_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master in mode 0; returns the first 32 bits seen on miso.
  task automatic xfer(input logic [31:0] w, input int nbits, input string name);
    logic [31:0] rx = 32'h0;
    int fe0 = ferr_cnt;
    logic expect_fe = (!enable_n) && (nbits != 32);
    ss_n = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 32) ? w[31-i] : 1'b0;
      tick(3);
      if (i < 32) rx = {rx[30:0], miso};
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
      tick(4);
    end
    ss_n = 1'b1;
    tick(6);
    if (nbits >= 32) check({name, "_miso"}, rx, enable_n ? 32'h0 : m_tx);
    check({name, "_ferr"}, ferr_cnt - fe0, {31'b0, expect_fe});
    pend_v = (!enable_n) && (nbits == 32);
    pend_w = w;
  endtask

  task automatic latch(input string name);
    int wr0 = wr_cnt;
    int rd0 = rd_cnt;
    int fe0 = ferr_cnt;
    int ewr = 0;
    int erd = 0;
    int efe = 0;
    if (!enable_n && pend_v) begin
      if (pend_w[31:24] == 8'h02) begin
        ewr = 1;
        exp_saddr  = pend_w[23:16];
        exp_sdata  = pend_w[15:0];
        exp_wr_cyc = cyc + 4;
      end else if (pend_w[31:24] == 8'h01) begin
        erd = 1;
        exp_saddr  = pend_w[23:16];
        exp_sdata  = m_wdata;
        exp_rd_cyc = cyc + 4;
        m_tx = {8'h01, pend_w[23:16], reg_rdata};
      end else begin
        efe = 1;
      end
    end
    pend_v = 1'b0;
    latch_data_n = 1'b0;
    tick(4);
    latch_data_n = 1'b1;
    tick(8);
    check({name, "_wr_count"}, wr_cnt - wr0, ewr);
    check({name, "_rd_count"}, rd_cnt - rd0, erd);
    check({name, "_ferr"}, ferr_cnt - fe0, efe);
  endtask

  initial begin
    tick(3);
    check("reset_outputs", {reg_wr_en, reg_rd_en, frame_err, miso, reg_addr, reg_wdata, 4'b0}, 32'h0);
    rst = 1'b0;
    tick(5);

    xfer(32'h0202_0008, 32, "wr1");
    latch("wr1");
    check("wr1_addr_lit", {24'b0, reg_addr}, 32'h02);
    check("wr1_data_lit", {16'b0, reg_wdata}, 32'h0008);

    reg_rdata = 16'h000F;
    xfer(32'h0104_0000, 32, "rd1");
    latch("rd1");
    check("rd1_addr_lit", {24'b0, reg_addr}, 32'h04);
    check("rd1_wdata_hold", {16'b0, reg_wdata}, 32'h0008);
    check("rd1_model_lit", m_tx, 32'h0104_000F);

    xfer(32'h0203_ABCD, 32, "wr2");
    latch("wr2");
    check("wr2_data_lit", {16'b0, reg_wdata}, 32'hABCD);

    xfer(32'h0104_0000, 32, "rd2");
    latch("rd2");
    xfer(32'h0255_0055, 32, "rd2_repeat");
    pend_v = 1'b0;

    xfer(32'h0202_1111, 31, "short31");
    latch("short31");
    xfer(32'h0202_2222, 33, "long33");
    latch("long33");

    xfer(32'h0705_1234, 32, "badcmd");
    latch("badcmd");

    xfer(32'h0211_1111, 32, "hold_a");
    xfer(32'h0222_2222, 32, "hold_b");
    latch("hold_b");
    check("hold_addr_lit", {24'b0, reg_addr}, 32'h22);

    enable_n = 1'b1;
    tick(4);
    xfer(32'h0202_0008, 32, "dis");
    latch("dis");
    enable_n = 1'b0;
    tick(4);
    xfer(32'h0202_0008, 32, "reen");
    latch("reen");
    check("reen_data_lit", {16'b0, reg_wdata}, 32'h0008);

    // Reset halfway through a write frame.
    ss_n = 1'b0;
    tick(4);
    for (int i = 0; i < 32; i++) begin
      if (i == 16) begin
        rst = 1'b1;
        tick(2);
        check("midrst_outputs", {reg_wr_en, reg_rd_en, frame_err, miso, reg_addr, reg_wdata, 4'b0}, 32'h0);
        rst = 1'b0;
        m_tx = 32'h0;
      end
      mosi = (32'h0209_0099 >> (31 - i)) & 32'h1;
      tick(3);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
      tick(4);
    end
    ss_n = 1'b1;
    tick(6);
    pend_v = 1'b0;
    latch("midrst");
    xfer(32'h0203_0003, 32, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
